// File: rtl/demux_1x8_deserializer_if.sv
// Serial-link and word-output signals of the 1:8 deserializer.
// Optional parity_err member exists only with DESER_PARITY_CHECK_EN defined.
interface demux_1x8_deserializer_if #(
   parameter int DATA_W = 8
);
   logic              ser_in;
   logic              ser_valid;
   logic              ser_sync;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;
`ifdef DESER_PARITY_CHECK_EN
   logic              parity_err;
`endif

   // master: link transmitter plus word consumer; slave: the deserializer
   modport master (
      output ser_in, ser_valid, ser_sync, data_ready,
      input  data_out, data_valid
`ifdef DESER_PARITY_CHECK_EN
      , input parity_err
`endif
   );

   modport slave (
      input  ser_in, ser_valid, ser_sync, data_ready,
      output data_out, data_valid
`ifdef DESER_PARITY_CHECK_EN
      , output parity_err
`endif
   );
endinterface

// File: rtl/demux_1x8_deserializer.sv
// Bit-serial receiver: a select counter steers each qualified bit into its word position.
// Define DESER_PARITY_CHECK_EN to append an even-parity bit to each frame.
module demux_1x8_deserializer #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   demux_1x8_deserializer_if.slave  bus,
   output logic [SEL_W-1:0]         sel_out,
   output logic                     busy,
   output logic                     overrun,
   input  logic                     overrun_clr
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(DATA_W - 1);

`ifdef DESER_PARITY_CHECK_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] asm_q, asm_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dvalid_q, dvalid_d;
   logic              ovr_q, ovr_d;
   logic              word_done;
   logic [DATA_W-1:0] word_new;
`ifdef DESER_PARITY_CHECK_EN
   logic              perr_q, perr_d, perr_new;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         asm_q    <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         ovr_q    <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
         perr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         asm_q    <= asm_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         ovr_q    <= ovr_d;
`ifdef DESER_PARITY_CHECK_EN
         perr_q   <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      asm_d     = asm_q;
      dout_d    = dout_q;
      dvalid_d  = dvalid_q;
      ovr_d     = ovr_q & ~overrun_clr;
      word_done = 1'b0;
      word_new  = asm_q;
`ifdef DESER_PARITY_CHECK_EN
      perr_d    = perr_q;
      perr_new  = 1'b0;
`endif

      if (dvalid_q && bus.data_ready)
         dvalid_d = 1'b0;

      if (bus.ser_valid) begin
         // sync always (re)starts a frame at position 0, from any state
         if (bus.ser_sync) begin
            asm_d    = '0;
            asm_d[0] = bus.ser_in;
            sel_d    = SEL_W'(1);
            state_d  = SHIFT;
         end else begin
            case (state_q)
               SHIFT: begin
                  asm_d[sel_q] = bus.ser_in;
                  sel_d        = sel_q + SEL_W'(1);
                  if (sel_q == LAST) begin
`ifdef DESER_PARITY_CHECK_EN
                     state_d   = PARITY;
`else
                     state_d   = IDLE;
                     word_done = 1'b1;
                     word_new  = asm_d;
`endif
                  end
               end
`ifdef DESER_PARITY_CHECK_EN
               PARITY: begin
                  state_d   = IDLE;
                  word_done = 1'b1;
                  word_new  = asm_q;
                  perr_new  = (^asm_q) ^ bus.ser_in;
               end
`endif
               default: ;
            endcase
         end
      end

      // a slot frees up on the same edge it is read, so completion can refill it
      if (word_done) begin
         if (!dvalid_q || bus.data_ready) begin
            dout_d   = word_new;
            dvalid_d = 1'b1;
`ifdef DESER_PARITY_CHECK_EN
            perr_d   = perr_new;
`endif
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.data_valid = dvalid_q;
`ifdef DESER_PARITY_CHECK_EN
   assign bus.parity_err = perr_q;
`endif
   assign sel_out = sel_q;
   assign busy    = (state_q != IDLE);
   assign overrun = ovr_q;

endmodule

// File: tb/tb_demux_1x8_deserializer.sv
// Directed bench for demux_1x8_deserializer: vector table of frames plus hand sequences.
module tb_demux_1x8_deserializer;

   logic       clk;
   logic       rst_n;
   logic [2:0] sel_out;
   logic       busy;
   logic       overrun;
   logic       overrun_clr;
   int         n_cmp;
   int         n_bad;

   demux_1x8_deserializer_if #(.DATA_W(8)) bus ();

   demux_1x8_deserializer #(.DATA_W(8), .SEL_W(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .sel_out     (sel_out),
      .busy        (busy),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0] word;
      int         gap;
      bit         pre_drain;
      bit         clr_pre;
      bit         rdy_last;
      logic [7:0] exp_data;
      bit         exp_valid;
      bit         exp_ovr;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input logic s, input logic rdy);
      bus.ser_in     = b;
      bus.ser_valid  = 1'b1;
      bus.ser_sync   = s;
      bus.data_ready = rdy;
      @(posedge clk);
      #1;
      bus.ser_in     = 1'b0;
      bus.ser_valid  = 1'b0;
      bus.ser_sync   = 1'b0;
      bus.data_ready = 1'b0;
   endtask

   // bits lo..hi of word, LSB first; bit 0 carries sync; parity bit follows bit 7
   task automatic send_range(input logic [7:0] word, input int lo, input int hi,
                             input int gap, input bit rdy_last, input bit bad_par);
      bit par_mode;
`ifdef DESER_PARITY_CHECK_EN
      par_mode = 1'b1;
`else
      par_mode = 1'b0;
`endif
      for (int k = lo; k <= hi; k++) begin
         send_bit(word[k], (k == 0), rdy_last && (k == 7) && !par_mode);
         if (k < hi) idle(gap);
      end
      if (par_mode && hi == 7) begin
         idle(gap);
         send_bit((^word) ^ bad_par, 1'b0, rdy_last);
      end
   endtask

   task automatic drain();
      bus.data_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.data_ready = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n          = 1'b0;
      overrun_clr    = 1'b0;
      bus.ser_in     = 1'b0;
      bus.ser_valid  = 1'b0;
      bus.ser_sync   = 1'b0;
      bus.data_ready = 1'b0;

      //          word   gap drn clr rdy  exp_data vld ovr
      vecs[0] = '{8'h4D, 0,  0,  0,  0,   8'h4D,   1,  0};
      vecs[1] = '{8'h4D, 2,  1,  0,  0,   8'h4D,   1,  0};
      vecs[2] = '{8'hA5, 0,  1,  0,  0,   8'hA5,   1,  0};
      vecs[3] = '{8'h3C, 0,  0,  0,  0,   8'hA5,   1,  1};
      vecs[4] = '{8'h3C, 0,  0,  1,  1,   8'h3C,   1,  0};
      vecs[5] = '{8'h81, 1,  0,  0,  1,   8'h81,   1,  0};
      vecs[6] = '{8'h00, 0,  1,  0,  0,   8'h00,   1,  0};
      vecs[7] = '{8'hFF, 0,  0,  0,  0,   8'h00,   1,  1};

      #12;
      chk("reset data_out",   bus.data_out,   8'h00);
      chk("reset data_valid", bus.data_valid, 1'b0);
      chk("reset sel_out",    sel_out,        3'd0);
      chk("reset busy",       busy,           1'b0);
      chk("reset overrun",    overrun,        1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].pre_drain) drain();
         if (vecs[i].clr_pre) begin
            overrun_clr = 1'b1;
            idle(1);
            overrun_clr = 1'b0;
         end
         send_range(vecs[i].word, 0, 7, vecs[i].gap, vecs[i].rdy_last, 1'b0);
         chk($sformatf("v%0d data_out", i),   bus.data_out,   vecs[i].exp_data);
         chk($sformatf("v%0d data_valid", i), bus.data_valid, vecs[i].exp_valid);
         chk($sformatf("v%0d overrun", i),    overrun,        vecs[i].exp_ovr);
         chk($sformatf("v%0d sel_out", i),    sel_out,        3'd0);
         chk($sformatf("v%0d busy", i),       busy,           1'b0);
      end

      // set and clear of overrun on the same edge: set wins
      overrun_clr = 1'b1;
      send_range(8'h55, 0, 7, 0, 1'b0, 1'b0);
      overrun_clr = 1'b0;
      chk("set-wins overrun",  overrun,      1'b1);
      chk("set-wins data_out", bus.data_out, 8'h00);
      overrun_clr = 1'b1;
      idle(1);
      overrun_clr = 1'b0;
      chk("clr overrun", overrun, 1'b0);

      // transfer with no new word drops data_valid, word stays visible
      drain();
      chk("drain data_valid", bus.data_valid, 1'b0);
      chk("drain data_out",   bus.data_out,   8'h00);

      // ser_valid gaps hold select counter and busy
      send_range(8'h4D, 0, 2, 0, 1'b0, 1'b0);
      chk("gap sel before", sel_out, 3'd3);
      idle(3);
      chk("gap sel held",   sel_out, 3'd3);
      chk("gap busy held",  busy,    1'b1);
      chk("gap no valid",   bus.data_valid, 1'b0);
      send_range(8'h4D, 3, 7, 0, 1'b0, 1'b0);
      chk("gap data_out",   bus.data_out,   8'h4D);
      chk("gap data_valid", bus.data_valid, 1'b1);
      drain();

      // mid-frame resync discards the partial word
      send_range(8'h0B, 0, 4, 0, 1'b0, 1'b0);
      chk("partial sel",   sel_out,        3'd5);
      chk("partial valid", bus.data_valid, 1'b0);
      send_range(8'hFF, 0, 0, 0, 1'b0, 1'b0);
      chk("resync sel",  sel_out, 3'd1);
      chk("resync busy", busy,    1'b1);
      send_range(8'hFF, 1, 7, 0, 1'b0, 1'b0);
      chk("resync data_out",   bus.data_out,   8'hFF);
      chk("resync data_valid", bus.data_valid, 1'b1);
      chk("resync overrun",    overrun,        1'b0);

      // asynchronous reset between edges, mid-frame
      send_range(8'h81, 0, 3, 0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async rst data_out",   bus.data_out,   8'h00);
      chk("async rst data_valid", bus.data_valid, 1'b0);
      chk("async rst sel_out",    sel_out,        3'd0);
      chk("async rst busy",       busy,           1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_range(8'h81, 0, 7, 0, 1'b0, 1'b0);
      chk("post rst data_out",   bus.data_out,   8'h81);
      chk("post rst data_valid", bus.data_valid, 1'b1);
      chk("post rst overrun",    overrun,        1'b0);

`ifdef DESER_PARITY_CHECK_EN
      drain();
      send_range(8'h4D, 0, 7, 0, 1'b0, 1'b0);
      chk("parity ok data_out", bus.data_out,   8'h4D);
      chk("parity ok err",      bus.parity_err, 1'b0);
      drain();
      send_range(8'h4D, 0, 7, 0, 1'b0, 1'b1);
      chk("parity bad valid", bus.data_valid, 1'b1);
      chk("parity bad err",   bus.parity_err, 1'b1);
      idle(2);
      chk("parity err held",  bus.parity_err, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
